// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher_pkg: bus widths and constants shared by the fetch unit and its icache.
package inst_fetcher_pkg;
    localparam int INST_BUS   = 32;
    localparam int ADDR_BUS   = 32;
    localparam int IC_IDX_BUS = 6;
    localparam int IC_TAG_BUS = ADDR_BUS - IC_IDX_BUS - 2;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic [INST_BUS-1:0] NULL = '0;
endpackage

// File: rtl/if_icache.sv
// if_icache: direct-mapped one-word-per-line instruction cache with combinational lookup
// and synchronous fill; valid bits clear asynchronously on reset.
module if_icache
    import inst_fetcher_pkg::*;
#(
    parameter int IDX_W  = IC_IDX_BUS,
    parameter int ADDR_W = ADDR_BUS,
    parameter int INST_W = INST_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:2] rd_addr,
    output logic              hit,
    output logic [INST_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:2] wr_addr,
    input  logic [INST_W-1:0] wr_data
);
    localparam int LINES = 1 << IDX_W;
    logic [INST_W-1:0]         data [LINES];
    logic [ADDR_W-IDX_W-3:0]   tag  [LINES];
    logic [LINES-1:0]          valid;
    logic [IDX_W-1:0]          rd_idx, wr_idx;
    assign rd_idx  = rd_addr[IDX_W+1:2];
    assign wr_idx  = wr_addr[IDX_W+1:2];
    assign hit     = valid[rd_idx] && tag[rd_idx] == rd_addr[ADDR_W-1:IDX_W+2];
    assign rd_data = data[rd_idx];
    always_ff @(posedge clk or negedge rst)
        if (!rst) valid <= '0;
        else if (wr_en) valid[wr_idx] <= TRUE;
    // Data and tag need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk)
        if (wr_en) begin
            data[wr_idx] <= wr_data;
            tag[wr_idx]  <= wr_addr[ADDR_W-1:IDX_W+2];
        end
endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: owns the PC, pushes icache hits into the IQ and turns misses into
// word requests to the memory controller; clr redirects fetch.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int IDX_W  = IC_IDX_BUS,
    parameter int ADDR_W = ADDR_BUS,
    parameter int INST_W = INST_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_pc,
    input  logic              IQ_nxt_full,
    output logic              IF_S,
    output logic [INST_W-1:0] IF_Inst,
    output logic [ADDR_W-1:0] IF_pc,
    output logic              MC_req,
    output logic [ADDR_W-1:0] MC_addr,
    input  logic              MC_done,
    input  logic [INST_W-1:0] MC_data
);
    typedef enum logic {IDLE, MISS} state_t;
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              hit, fill;
    logic [INST_W-1:0] line;
    assign fill = rdy && !clr && state == MISS && MC_done;
    if_icache #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .INST_W(INST_W)) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (pc[ADDR_W-1:2]),
        .hit     (hit),
        .rd_data (line),
        .wr_en   (fill),
        .wr_addr (MC_addr[ADDR_W-1:2]),
        .wr_data (MC_data)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= '0;
            IF_S    <= FALSE;
            IF_Inst <= '0;
            IF_pc   <= '0;
            MC_req  <= FALSE;
            MC_addr <= '0;
        end else if (clr) begin
            state  <= IDLE;
            pc     <= clr_pc;
            IF_S   <= FALSE;
            MC_req <= FALSE;
        end else if (!rdy) begin
            IF_S <= FALSE;
        end else if (state == IDLE) begin
            IF_S <= hit && !IQ_nxt_full;
            if (hit && !IQ_nxt_full) begin
                IF_Inst <= line;
                IF_pc   <= pc;
                pc      <= pc + ADDR_W'(4);
            end else if (!hit) begin
                state   <= MISS;
                MC_req  <= TRUE;
                MC_addr <= {pc[ADDR_W-1:2], 2'b00};
            end
        end else begin
            // The filled word is delivered by the next IDLE lookup, never from here.
            IF_S <= FALSE;
            if (MC_done) begin
                state  <= IDLE;
                MC_req <= FALSE;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed test-plan scenarios plus randomized traffic, every cycle
// compared against an address-level model of the fetch unit and a simple MC responder.
module tb_inst_fetcher;
    logic        clk = 0;
    logic        rst, rdy, clr, IQ_nxt_full, MC_done;
    logic [31:0] clr_pc, MC_data, IF_Inst, IF_pc, MC_addr;
    logic        IF_S, MC_req;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    inst_fetcher dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .clr_pc(clr_pc),
        .IQ_nxt_full(IQ_nxt_full), .IF_S(IF_S), .IF_Inst(IF_Inst), .IF_pc(IF_pc),
        .MC_req(MC_req), .MC_addr(MC_addr), .MC_done(MC_done), .MC_data(MC_data)
    );

    // Model: cache as "which word address lives in each line", memory as a hash.
    logic [31:0] m_pc, e_inst, e_ipc, e_addr;
    logic [31:0] line_addr [64];
    bit          line_v [64];
    bit          m_wait, e_s, e_req;
    int          lat_cfg = 2, lat_cnt = 0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_wait = 0; e_s = 0; e_inst = 0; e_ipc = 0; e_req = 0; e_addr = 0; lat_cnt = 0;
        foreach (line_v[i]) line_v[i] = 0;
    endtask

    task automatic model_step();
        if (clr) begin
            m_pc = clr_pc; m_wait = 0; e_req = 0; e_s = 0;
        end else if (!rdy) begin
            e_s = 0;
        end else if (m_wait) begin
            e_s = 0;
            if (MC_done) begin
                line_addr[e_addr[7:2]] = e_addr;
                line_v[e_addr[7:2]] = 1;
                m_wait = 0; e_req = 0;
            end
        end else if (line_v[m_pc[7:2]] && line_addr[m_pc[7:2]] == m_pc) begin
            e_s = !IQ_nxt_full;
            if (!IQ_nxt_full) begin
                e_inst = mem_word(m_pc); e_ipc = m_pc; m_pc = m_pc + 4;
            end
        end else begin
            e_s = 0; m_wait = 1; e_req = 1; e_addr = m_pc; lat_cnt = lat_cfg;
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        chk("IF_S", {31'b0, IF_S}, {31'b0, e_s});
        chk("IF_Inst", IF_Inst, e_inst);
        chk("IF_pc", IF_pc, e_ipc);
        chk("MC_req", {31'b0, MC_req}, {31'b0, e_req});
        chk("MC_addr", MC_addr, e_addr);
    endtask

    task automatic tick(bit force_done);
        if (force_done || (e_req && rdy && lat_cnt == 0)) begin
            MC_done = 1; MC_data = mem_word(e_addr);
        end else begin
            MC_done = 0; MC_data = $urandom;
            if (e_req && rdy && lat_cnt > 0) lat_cnt--;
        end
        model_step();
        @(posedge clk); #1;
        check_outs();
    endtask

    task automatic run_to(logic [31:0] p);
        int n = 0;
        while (!(IF_S === 1'b1 && IF_pc === p) && n < 60) begin tick(0); n++; end
        chk("reach", {31'b0, IF_S === 1'b1 && IF_pc === p}, 1);
    endtask

    task automatic redirect(logic [31:0] p);
        clr = 1; clr_pc = p; tick(0); clr = 0;
    endtask

    initial begin
        int cnt;
        rst = 0; rdy = 0; clr = 0; clr_pc = 0; IQ_nxt_full = 0; MC_done = 0; MC_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outs();
        rst = 1; rdy = 1;

        // cold start
        lat_cfg = 3;
        tick(0);
        chk("cold_req", {31'b0, MC_req}, 1);
        chk("cold_addr", MC_addr, 0);
        run_to(0);
        chk("cold_inst", IF_Inst, 32'h13);
        tick(0);
        chk("next_req", {31'b0, MC_req}, 1);
        chk("next_addr", MC_addr, 4);

        // warm loop
        lat_cfg = 1;
        run_to(12);
        redirect(0);
        for (int i = 0; i < 4; i++) begin
            tick(0);
            chk("warm_s", {31'b0, IF_S}, 1);
            chk("warm_pc", IF_pc, i * 4);
            chk("warm_noreq", {31'b0, MC_req}, 0);
        end

        // back-pressure
        run_to(32'h28);
        IQ_nxt_full = 1;
        redirect(32'h20);
        repeat (5) begin tick(0); chk("bp_idle", {31'b0, IF_S}, 0); end
        IQ_nxt_full = 0;
        cnt = 0;
        repeat (6) begin tick(0); if (IF_S === 1'b1 && IF_pc === 32'h20) cnt++; end
        chk("bp_once", cnt, 1);

        // redirect in the same cycle as MC_done
        lat_cfg = 100;
        redirect(32'h80);
        tick(0);
        chk("mm_addr", MC_addr, 32'h80);
        clr = 1; clr_pc = 32'h100; tick(1); clr = 0;
        tick(0);
        chk("mm_req", {31'b0, MC_req}, 1);
        chk("mm_newaddr", MC_addr, 32'h100);
        lat_cfg = 2; lat_cnt = 2;
        run_to(32'h100);
        redirect(32'h80);
        tick(0);
        chk("mm_nofill", MC_addr, 32'h80);
        run_to(32'h84);

        // pause mid-stream
        redirect(32'h20);
        tick(0);
        chk("pause_pre", IF_pc, 32'h20);
        rdy = 0;
        repeat (4) begin tick(0); chk("pause_s", {31'b0, IF_S}, 0); end
        rdy = 1;
        tick(0);
        chk("pause_resume", IF_pc, 32'h24);

        // asynchronous reset during a miss
        lat_cfg = 100;
        redirect(32'h200);
        tick(0);
        chk("ar_req", {31'b0, MC_req}, 1);
        #3 rst = 0;
        #1;
        chk("ar_req_low", {31'b0, MC_req}, 0);
        chk("ar_addr", MC_addr, 0);
        model_reset();
        #1 rst = 1;
        lat_cfg = 2;
        tick(0);
        chk("ar_restart", MC_addr, 0);
        run_to(0);
        chk("ar_inst", IF_Inst, 32'h13);

        // pc wraps past the top of the address space
        redirect(32'hFFFF_FFFC);
        run_to(32'hFFFF_FFFC);
        tick(0);
        chk("wrap_s", {31'b0, IF_S}, 1);
        chk("wrap_pc", IF_pc, 0);

        // randomized traffic
        repeat (3000) begin
            rdy = ($urandom % 8) != 0;
            IQ_nxt_full = ($urandom % 4) == 0;
            clr = ($urandom % 40) == 0;
            clr_pc = $urandom_range(0, 23) * 4 + ((($urandom % 3) == 0) ? 32'h100 : 32'h0);
            lat_cfg = $urandom_range(0, 4);
            tick(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Instruction fetch unit at the producer end of the IF→IQ interface. It owns the program counter and looks the PC up in a direct-mapped instruction cache. Hits are pushed into the instruction queue with a one-cycle `IF_S` strobe. Misses become 32-bit word requests to the memory controller (MC). Redirection on `clr` restarts fetch at a supplied PC.

## Interface
Parameters:
- `IDX_W`, default 6: icache index width, giving 2^IDX_W one-word lines.
- `ADDR_W`, default 32: address width.
- `INST_W`, default 32: instruction width.

Ports:
- `clk` in, 1: the single clock; all state on posedge.
- `rst` in, 1: asynchronous, active-low reset. Asserting it (low) clears state immediately, independent of `clk`.
- `rdy` in, 1: global run enable; low means pause.
- `clr` in, 1: pipeline flush/redirect (synchronous).
- `clr_pc` in, ADDR_W: fetch target when `clr`=1.
- `IQ_nxt_full` in, 1: queue cannot accept a push at this edge.
- `IF_S` out, 1: push strobe to the IQ, one cycle per instruction.
- `IF_Inst` out, INST_W: instruction being pushed.
- `IF_pc` out, ADDR_W: PC of `IF_Inst`.
- `MC_req` out, 1: word-fetch request, held until `MC_done`.
- `MC_addr` out, ADDR_W: word address of the request; bits [1:0] are always 0.
- `MC_done` in, 1: one-cycle pulse; `MC_data` is valid in that cycle.
- `MC_data` in, INST_W: fetched word.

## Operation
- Cache address split:
  - index = `pc[IDX_W+1:2]`
  - tag = `pc[ADDR_W-1:IDX_W+2]`
  - hit = valid[index] && tag matches.
- FSM states: IDLE (lookup) and MISS (request outstanding).
- IDLE, `rdy`=1, `clr`=0:
  - Hit and `IQ_nxt_full`=0:
    - register `IF_S`=1, `IF_Inst`=line data, `IF_pc`=pc;
    - pc ← pc+4 (wraps modulo 2^ADDR_W).
  - Hit and `IQ_nxt_full`=1:
    - `IF_S`=0; pc holds.
  - Miss:
    - `MC_req`←1, `MC_addr`←pc;
    - go to MISS; `IF_S`=0.
- MISS:
  - Hold `MC_req`/`MC_addr` until `MC_done`.
  - On `MC_done`, write the line (data, tag, valid←1), drop `MC_req` and return to IDLE.
  - The instruction is **not** pushed from MISS. It is delivered by the following IDLE hit, so a full IQ at fill time needs no special case.
- `clr`=1 (priority over everything except reset):
  - pc ← `clr_pc`; state ← IDLE; `MC_req` ← 0; `IF_S` ← 0.
  - An `MC_done` arriving in the same cycle is ignored (no fill).
  - Cache valid bits are preserved.
  - The MC receives the same `clr` and abandons its transaction.
- `rdy`=0:
  - `IF_S` ← 0; pc, state, cache and `MC_req`/`MC_addr` hold.
  - `MC_done` is not sampled.
- Reset values:
  - pc=0, state=IDLE, all valid=0;
  - `IF_S`=0, `IF_Inst`=0, `IF_pc`=0, `MC_req`=0, `MC_addr`=0.

## Timing
- All outputs are registered.
- Hit path: lookup at edge k, `IF_S` high during cycle k+1. Sustained throughput is one instruction per cycle while hitting and not full.
- `IQ_nxt_full` is sampled at the same edge that would raise `IF_S`. No push ever occurs on an edge where it is 1.
- Miss path:
  - miss detected at edge k;
  - `MC_req` high from k+1;
  - `MC_done` arrives at cycle m, fill at edge m;
  - IDLE lookup hits at edge m+1;
  - `IF_S` high in cycle m+2.
- `IF_S` is never high for two consecutive cycles with the same `IF_pc`.
- After `clr` at edge k, the first push has `IF_pc`=`clr_pc`, no earlier than cycle k+2.

## Structure
- Shared constants go in `Definition.v`: `InstBus`, `AddrBus`, `True`/`False`, `Null`, plus new `ICIdxBus`/`ICTagBus` derived from `IDX_W`.
- FSM state encodings are local to this block.
- One sub-module, `if_icache`:
  - data/tag/valid arrays with a combinational read port (hit, data) and a synchronous write port;
  - asynchronous valid clear on `rst` low.
- FSM, pc and handshake logic live in `inst_fetcher`.

## Test plan
- Cold start: reset low then high; MC returns 0x00000013 at address 0 after 3 cycles → `MC_req`=1 with `MC_addr`=0, then `IF_S`=1 with `IF_pc`=0 and `IF_Inst`=0x00000013; the next request has `MC_addr`=4.
- Warm loop: preload pc 0–12, `clr` with `clr_pc`=0 → four consecutive `IF_S` cycles with pc 0, 4, 8, 12 and no `MC_req`.
- Back-pressure: `IQ_nxt_full`=1 for 5 cycles while hitting → `IF_S`=0 throughout; pc 0x20 is pushed exactly once after release, with no skip or duplicate.
- Redirect mid-miss: `clr` with `clr_pc`=0x100 while MISS, `MC_done` in the same cycle → no fill at the old index; `MC_addr`=0x100 is requested next.
- Pause: `rdy`=0 for 4 cycles mid-hit-stream → `IF_S`=0 and pc frozen; the stream resumes at the same pc.
- Async reset mid-miss: `rst` pulsed low between edges → `MC_req`=0 immediately, all lines invalid, fetch restarts at pc 0.
